// File: rtl/two_source_bus_arbiter.sv
// Round-robin arbiter between two valid/ready requesters feeding a registered 16-bit output stage.
// Optional grant counters are built when ARB_GRANT_STATS_EN is defined.
module two_source_bus_arbiter #(
    parameter int unsigned MAX_BURST = 2
) (
    input  logic        in_clk,
    input  logic        in_reset_n,
    input  logic [15:0] in_one,
    input  logic        in_one_valid,
    output logic        ou_one_ready,
    input  logic [15:0] in_two,
    input  logic        in_two_valid,
    output logic        ou_two_ready,
    output logic [15:0] ou_result,
    output logic        ou_result_valid,
    input  logic        in_result_ready,
    output logic        ou_select,
    input  logic        in_stats_clear,
    output logic [15:0] ou_one_count,
    output logic [15:0] ou_two_count
);

    typedef enum logic {
        SRC_ONE = 1'b0,
        SRC_TWO = 1'b1
    } src_e;

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    logic [15:0] result_q;
    logic        result_valid_q;
    src_e        last_q;
    logic [3:0]  burst_cnt_q;

    logic        slot_open;
    logic        grant_any;
    src_e        grant;

    // A zero burst count only exists straight after reset; treating it as an
    // exhausted burst hands the first contention to the requester that is not `last`.
    always_comb begin
        slot_open = !result_valid_q || in_result_ready;
        grant     = last_q;
        grant_any = 1'b0;
        if (in_reset_n && slot_open) begin
            if (in_one_valid && in_two_valid) begin
                grant_any = 1'b1;
                if (burst_cnt_q != '0 && burst_cnt_q < BURST_LIMIT) begin
                    grant = last_q;
                end else begin
                    grant = (last_q == SRC_ONE) ? SRC_TWO : SRC_ONE;
                end
            end else if (in_one_valid) begin
                grant_any = 1'b1;
                grant     = SRC_ONE;
            end else if (in_two_valid) begin
                grant_any = 1'b1;
                grant     = SRC_TWO;
            end
        end
    end

    assign ou_one_ready    = grant_any && (grant == SRC_ONE);
    assign ou_two_ready    = grant_any && (grant == SRC_TWO);
    assign ou_select       = grant;
    assign ou_result       = result_q;
    assign ou_result_valid = result_valid_q;

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            result_q       <= '0;
            result_valid_q <= 1'b0;
            last_q         <= SRC_TWO;
            burst_cnt_q    <= '0;
        end else if (grant_any) begin
            result_q       <= (grant == SRC_TWO) ? in_two : in_one;
            result_valid_q <= 1'b1;
            if (grant == last_q) begin
                if (burst_cnt_q < BURST_LIMIT) begin
                    burst_cnt_q <= burst_cnt_q + 4'd1;
                end
            end else begin
                last_q      <= grant;
                burst_cnt_q <= 4'd1;
            end
        end else if (in_result_ready) begin
            result_valid_q <= 1'b0;
        end
    end

`ifdef ARB_GRANT_STATS_EN
    logic [15:0] one_cnt_q;
    logic [15:0] two_cnt_q;

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            one_cnt_q <= '0;
            two_cnt_q <= '0;
        end else if (in_stats_clear) begin
            one_cnt_q <= '0;
            two_cnt_q <= '0;
        end else if (grant_any) begin
            if (grant == SRC_ONE && one_cnt_q != '1) begin
                one_cnt_q <= one_cnt_q + 16'd1;
            end
            if (grant == SRC_TWO && two_cnt_q != '1) begin
                two_cnt_q <= two_cnt_q + 16'd1;
            end
        end
    end

    assign ou_one_count = one_cnt_q;
    assign ou_two_count = two_cnt_q;
`else
    logic stats_clear_unused;
    assign stats_clear_unused = in_stats_clear;
    assign ou_one_count       = '0;
    assign ou_two_count       = '0;
`endif

endmodule

// File: tb/tb_two_source_bus_arbiter.sv
// Directed bench for two_source_bus_arbiter: two instances (MAX_BURST 2 and 1) share stimulus,
// a grant-history model checks every cycle, and literal expectations pin the scenarios.
module tb_two_source_bus_arbiter;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] one, two;
    logic        one_v, two_v, rr, clr;

    logic        a_one_rdy, a_two_rdy, a_res_v, a_sel;
    logic [15:0] a_res, a_c1, a_c2;
    logic        b_one_rdy, b_two_rdy, b_res_v, b_sel;
    logic [15:0] b_res, b_c1, b_c2;

    int checks   = 0;
    int failures = 0;

    // Expected contention order, 1 = one, 2 = two
    int exp_a[6] = '{1, 1, 2, 2, 1, 1};
    int exp_b[6] = '{1, 2, 1, 2, 1, 2};

    always #5 clk = ~clk;

    two_source_bus_arbiter #(.MAX_BURST(2)) dut_a (
        .in_clk(clk), .in_reset_n(rst_n),
        .in_one(one), .in_one_valid(one_v), .ou_one_ready(a_one_rdy),
        .in_two(two), .in_two_valid(two_v), .ou_two_ready(a_two_rdy),
        .ou_result(a_res), .ou_result_valid(a_res_v), .in_result_ready(rr),
        .ou_select(a_sel), .in_stats_clear(clr),
        .ou_one_count(a_c1), .ou_two_count(a_c2)
    );

    two_source_bus_arbiter #(.MAX_BURST(1)) dut_b (
        .in_clk(clk), .in_reset_n(rst_n),
        .in_one(one), .in_one_valid(one_v), .ou_one_ready(b_one_rdy),
        .in_two(two), .in_two_valid(two_v), .ou_two_ready(b_two_rdy),
        .ou_result(b_res), .ou_result_valid(b_res_v), .in_result_ready(rr),
        .ou_select(b_sel), .in_stats_clear(clr),
        .ou_one_count(b_c1), .ou_two_count(b_c2)
    );

    // Model: history of granted sources (0 = one, 1 = two) plus output stage and counts
    bit          hist_a[$];
    bit          hist_b[$];
    logic [15:0] m_res[2] = '{16'h0000, 16'h0000};
    logic        m_val[2] = '{1'b0, 1'b0};
    logic [15:0] m_c1[2]  = '{16'h0000, 16'h0000};
    logic [15:0] m_c2[2]  = '{16'h0000, 16'h0000};
    bit          preload_req = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Who must be granted now: -1 none, 0 one, 1 two
    function automatic int pick(input bit h[$], input int mb, input logic mval);
        int  s;
        int  i;
        bit  tail;
        if (!rst_n) return -1;
        if (mval && !rr) return -1;
        if (one_v && two_v) begin
            if (h.size() == 0) return 0;
            tail = h[h.size()-1];
            s = 0;
            i = h.size() - 1;
            while (i >= 0) begin
                if (h[i] != tail) break;
                s++;
                i--;
            end
            return (s < mb) ? int'(tail) : 1 - int'(tail);
        end
        if (one_v) return 0;
        if (two_v) return 1;
        return -1;
    endfunction

    task automatic model_step(input int k);
        int g;
        if (k == 0) g = pick(hist_a, 2, m_val[0]);
        else        g = pick(hist_b, 1, m_val[1]);
        if (g >= 0) begin
            m_res[k] <= (g == 1) ? two : one;
            m_val[k] <= 1'b1;
            if (k == 0) hist_a.push_back(g[0]);
            else        hist_b.push_back(g[0]);
        end else if (rr) begin
            m_val[k] <= 1'b0;
        end
        if (clr) begin
            m_c1[k] <= '0;
            m_c2[k] <= '0;
        end else if (preload_req && k == 0) begin
            m_c1[k] <= 16'hFFFF;
        end else begin
            if (g == 0 && m_c1[k] != 16'hFFFF) m_c1[k] <= m_c1[k] + 16'd1;
            if (g == 1 && m_c2[k] != 16'hFFFF) m_c2[k] <= m_c2[k] + 16'd1;
        end
        if (hist_a.size() > 16) void'(hist_a.pop_front());
        if (hist_b.size() > 16) void'(hist_b.pop_front());
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_a.delete();
            hist_b.delete();
            for (int k = 0; k < 2; k++) begin
                m_res[k] <= '0;
                m_val[k] <= 1'b0;
                m_c1[k]  <= '0;
                m_c2[k]  <= '0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    task automatic compare_dut(input string tag, input bit h[$], input int mb, input int k,
                               input logic r1, input logic r2, input logic sel, input logic rv,
                               input logic [15:0] res, input logic [15:0] c1, input logic [15:0] c2);
        int          g;
        logic        esel;
        logic [15:0] e1, e2;
        g = pick(h, mb, m_val[k]);
        if (g >= 0)             esel = g[0];
        else if (h.size() == 0) esel = 1'b1;
        else                    esel = h[h.size()-1];
`ifdef ARB_GRANT_STATS_EN
        e1 = m_c1[k];
        e2 = m_c2[k];
`else
        e1 = '0;
        e2 = '0;
`endif
        chk({tag, "_one_ready"},   16'(r1),  16'(g == 0));
        chk({tag, "_two_ready"},   16'(r2),  16'(g == 1));
        chk({tag, "_select"},      16'(sel), 16'(esel));
        chk({tag, "_result_valid"}, 16'(rv), 16'(m_val[k]));
        chk({tag, "_result"},      res, m_res[k]);
        if (!(preload_req && k == 0)) chk({tag, "_one_count"}, c1, e1);
        chk({tag, "_two_count"},   c2, e2);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            compare_dut("a", hist_a, 2, 0, a_one_rdy, a_two_rdy, a_sel, a_res_v, a_res, a_c1, a_c2);
            compare_dut("b", hist_b, 1, 1, b_one_rdy, b_two_rdy, b_sel, b_res_v, b_res, b_c1, b_c2);
        end
    end

    initial begin
        one = '0; two = '0; one_v = 1'b0; two_v = 1'b0; rr = 1'b1; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset asserted with a word in flight
        one = 16'hAAAA; one_v = 1'b1;
        @(posedge clk); #1;
        chk("inflight_result", a_res, 16'hAAAA);
        rst_n = 1'b0;
        #1;
        chk("rst_result_a",  a_res, 16'h0000);
        chk("rst_valid_a",   16'(a_res_v), 16'h0000);
        chk("rst_one_rdy_a", 16'(a_one_rdy), 16'h0000);
        chk("rst_result_b",  b_res, 16'h0000);
        chk("rst_one_rdy_b", 16'(b_one_rdy), 16'h0000);
        one_v = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_valid", 16'(a_res_v), 16'h0000);
            chk("idle_sel_a", 16'(a_sel), 16'h0001);
            chk("idle_sel_b", 16'(b_sel), 16'h0001);
        end

        // Single requester stream
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            one = 16'(i); one_v = 1'b1;
            @(negedge clk);
            chk("stream_rdy_a", 16'(a_one_rdy), 16'h0001);
            chk("stream_rdy_b", 16'(b_one_rdy), 16'h0001);
            if (i > 1) chk("stream_result", a_res, 16'(i - 1));
            @(posedge clk); #1;
        end
        one_v = 1'b0;
        @(negedge clk);
        chk("stream_last", a_res, 16'h0004);

        // Contention from a fresh reset
        @(posedge clk); #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            one = 16'h1000 + 16'(i); two = 16'h2000 + 16'(i);
            one_v = 1'b1; two_v = 1'b1;
            @(negedge clk);
            chk("order_a", 16'({a_two_rdy, a_one_rdy}), 16'(exp_a[i]));
            chk("order_b", 16'({b_two_rdy, b_one_rdy}), 16'(exp_b[i]));
            chk("order_sel_a", 16'(a_sel), 16'(exp_a[i] - 1));
            chk("order_sel_b", 16'(b_sel), 16'(exp_b[i] - 1));
`ifdef ARB_GRANT_STATS_EN
            if (i == 4) begin
                chk("alt_one_count", b_c1, 16'd2);
                chk("alt_two_count", b_c2, 16'd2);
            end
`endif
            @(posedge clk); #1;
        end

        // Backpressure with both requesters valid
        one = 16'h1234; two_v = 1'b0;
        @(posedge clk); #1;
        rr = 1'b0; one = 16'h4321; two = 16'h5678; two_v = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_rdy_a", 16'({a_two_rdy, a_one_rdy}), 16'h0000);
            chk("stall_rdy_b", 16'({b_two_rdy, b_one_rdy}), 16'h0000);
            chk("stall_result_a", a_res, 16'h1234);
            chk("stall_result_b", b_res, 16'h1234);
            @(posedge clk); #1;
            one = one + 16'd1;
        end
        rr = 1'b1;
        @(negedge clk);
        chk("resume_rdy_a", 16'(a_two_rdy), 16'h0001);
        chk("resume_rdy_b", 16'(b_two_rdy), 16'h0001);
        @(posedge clk); #1;
        one_v = 1'b0; two_v = 1'b0; rr = 1'b0;
        @(negedge clk);
        chk("resume_result", a_res, 16'h5678);
        chk("resume_valid", 16'(a_res_v), 16'h0001);

        // Clear coinciding with a transfer
        @(posedge clk); #1;
        rr = 1'b1; one = 16'h00C1; one_v = 1'b1; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; one_v = 1'b0;
        @(negedge clk);
        chk("clear_one_a", a_c1, 16'h0000);
        chk("clear_two_a", a_c2, 16'h0000);
        chk("clear_one_b", b_c1, 16'h0000);

`ifdef ARB_GRANT_STATS_EN
        // Saturation from a preloaded count
        @(posedge clk); #1;
        force dut_a.one_cnt_q = 16'hFFFF;
        preload_req = 1'b1;
        @(posedge clk); #1;
        release dut_a.one_cnt_q;
        preload_req = 1'b0;
        one_v = 1'b1;
        @(posedge clk); #1;
        one_v = 1'b0;
        @(negedge clk);
        chk("sat_one_count", a_c1, 16'hFFFF);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
